sharp_reg_bank: RTL and testbench
=================================

Name: sharp_reg_bank

Overview:
- Register bank directly downstream of the bus slave decoder.
- Consumes the decoder's 5-bit register address and active-low one-cycle acknowledge strobe.
- Holds the sharpening engine's configuration registers (source/destination addresses, image dimensions, 3x3 kernel coefficients) and its control/status registers.
- Generates the engine start pulse, tracks busy/done, and drives read data and the interrupt back toward the DLX.

Parameters:
DATA_W, 32, bus data width.
DIM_W, 10, width of WIDTH/HEIGHT fields.
COEF_W, 8, width of each signed kernel coefficient.

Ports:
clk  input  1  system clock, all logic on rising edge.
reset  input  1  synchronous, active-high reset.
reg_address  input  5  word register index from the slave decoder.
SACK_N  input  1  active-low access strobe from the decoder; low for exactly one cycle per access.
WR_N  input  1  bus direction qualifier; 0 = write, 1 = read, sampled while SACK_N=0.
DI  input  DATA_W  bus write data, valid while SACK_N=0 and WR_N=0.
DO  output  DATA_W  registered read data.
DO_EN  output  1  read-drive enable for the bus tristate: ~SACK_N & WR_N, combinational.
eng_start  output  1  one-cycle start pulse to the sharpening engine.
eng_busy  input  1  engine busy level.
eng_done  input  1  one-cycle engine completion pulse.
src_addr  output  DATA_W  SRC register contents.
dst_addr  output  DATA_W  DST register contents.
img_width  output  DIM_W  WIDTH register contents.
img_height  output  DIM_W  HEIGHT register contents.
kernel  output  9*COEF_W  coefficients K0..K8, with K0 in the LSBs.
irq  output  1  interrupt level, registered.

Behaviour:
- Clocking: single clock domain (clk). reset is synchronous, active-high.
- Reset: all registers, DO, eng_start and irq go to 0, except K4 = 8'sd5 and K1 = K3 = K5 = K7 = -1. The reset kernel is the default 4-neighbour sharpen.
- Access cycle: any cycle with SACK_N=0. A write is SACK_N=0 and WR_N=0; a read is SACK_N=0 and WR_N=1.
- Register map (word index):
  - 0 CTRL: bit0 START (write-only, reads 0); bit1 IRQ_EN (r/w).
  - 1 STATUS: bit0 BUSY (live eng_busy); bit1 DONE (sticky); bit2 ERR (sticky). DONE and ERR are W1C; writes to BUSY are ignored.
  - 2 SRC, 3 DST: full DATA_W, r/w.
  - 4 WIDTH, 5 HEIGHT: low DIM_W bits r/w; upper bits read 0.
  - 6..14 K0..K8: low COEF_W bits stored; reads sign-extend to DATA_W.
  - 15..31: read 0; writes ignored.
- Write timing: writes take effect at the clock edge ending the access cycle.
- DO timing:
  - Every cycle, DO <= mux(reg_address), so DO lags the address by one cycle.
  - The decoder holds the address stable for at least one cycle before SACK_N falls, so DO is valid throughout the access cycle.
  - Reads have no side effects.
- Start:
  - A write to CTRL with DI[0]=1 while eng_busy=0 asserts eng_start for exactly one cycle, in the cycle after the access.
  - The same write with eng_busy=1 does not pulse eng_start and sets ERR.
  - Only one start can be outstanding: an internal pending flag suppresses a second start until eng_busy has been observed high or eng_done has pulsed.
- Done:
  - eng_done=1 sets DONE on the next edge.
  - If eng_done coincides with a W1C of DONE, set wins and DONE stays 1. The same set-wins rule applies to ERR.
  - START and W1C of DONE in a single CTRL write is impossible (separate registers). A START write clears DONE in the same edge: a new run invalidates the old result.
- irq: registered; irq <= DONE_next & IRQ_EN_next. It falls one cycle after DONE is cleared or IRQ_EN is cleared.
- Config writes while eng_busy=1 are accepted without guard; the engine is responsible for latching config at start.
- Reset in mid-operation: all state returns to reset values on the next edge. A pending eng_start pulse is cancelled, and eng_busy/eng_done are ignored during the reset cycle.
- SACK_N=0 with an unmapped address: no state change; DO=0.

Test Plan:
- Reset, then read regs 0..14 -> CTRL=0, STATUS=0; K4 reads 0x00000005; K1, K3, K5, K7 read 0xFFFFFFFF; others 0.
- Write SRC=0x00001000, WIDTH=0xFFFFF280, K0=0x000000FE, then read back -> 0x00001000, 0x00000280, 0xFFFFFFFE; write reg 20 = 0x1234 then read -> 0.
- Write CTRL=0x3 with eng_busy=0 -> eng_start high exactly one cycle, in the cycle after SACK_N low. Hold eng_busy for 10 cycles, then pulse eng_done -> STATUS reads 0x2 and irq=1 on the following cycle.
- Write STATUS=0x2 in the same cycle as an eng_done pulse -> DONE stays 1. A subsequent lone W1C -> STATUS=0x0 and irq falls one cycle later.
- Write CTRL=0x1 with eng_busy=1 -> no eng_start, STATUS reads 0x5. Then two back-to-back START writes with eng_busy=0 before busy rises -> exactly one eng_start pulse.
- Assert reset for one cycle while eng_start is pending and DONE=1 -> eng_start stays 0, STATUS=0, irq=0, kernel back to default.

Source files
------------

// File: rtl/sharp_reg_bank.sv
// Configuration and control/status register bank for the sharpening engine.
// Sits behind the bus slave decoder and drives start, read data and interrupt.
module sharp_reg_bank #(
    parameter int DATA_W = 32,
    parameter int DIM_W  = 10,
    parameter int COEF_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4:0]            reg_address,
    input  logic                  SACK_N,
    input  logic                  WR_N,
    input  logic [DATA_W-1:0]     DI,
    output logic [DATA_W-1:0]     DO,
    output logic                  DO_EN,
    output logic                  eng_start,
    input  logic                  eng_busy,
    input  logic                  eng_done,
    output logic [DATA_W-1:0]     src_addr,
    output logic [DATA_W-1:0]     dst_addr,
    output logic [DIM_W-1:0]      img_width,
    output logic [DIM_W-1:0]      img_height,
    output logic [9*COEF_W-1:0]   kernel,
    output logic                  irq
);

    logic [DATA_W-1:0] src_q, dst_q, do_q, do_d;
    logic [DIM_W-1:0]  width_q, height_q;
    logic [COEF_W-1:0] k_q [9];
    logic irq_en_q, irq_en_d;
    logic done_q, done_d;
    logic err_q, err_d;
    logic pending_q, pending_d;
    logic start_q, irq_d;

    logic accessWr, wrCtrl, wrStatus, startReq, startOk;

    // Default kernel is the 4-neighbour sharpen: centre 5, edge neighbours -1.
    function automatic logic [COEF_W-1:0] kDefault(input int idx);
        if (idx == 4)
            return COEF_W'(5);
        else if ((idx % 2) == 1)
            return '1;
        else
            return '0;
    endfunction

    assign accessWr = ~SACK_N & ~WR_N;
    assign wrCtrl   = accessWr && (reg_address == 5'd0);
    assign wrStatus = accessWr && (reg_address == 5'd1);
    assign startReq = wrCtrl & DI[0];
    assign startOk  = startReq & ~eng_busy & ~pending_q;

    // Sticky status bits: a set event beats a coincident write-one-to-clear,
    // and an accepted start discards the previous run's DONE.
    always_comb begin
        irq_en_d  = wrCtrl ? DI[1] : irq_en_q;
        done_d    = eng_done | (done_q & ~(wrStatus & DI[1]) & ~startOk);
        err_d     = (startReq & eng_busy) | (err_q & ~(wrStatus & DI[2]));
        pending_d = startOk | (pending_q & ~eng_busy & ~eng_done);
        irq_d     = done_d & irq_en_d;
    end

    always_comb begin
        do_d = '0;
        case (reg_address)
            5'd0: do_d[1]   = irq_en_q;
            5'd1: do_d[2:0] = {err_q, done_q, eng_busy};
            5'd2: do_d      = src_q;
            5'd3: do_d      = dst_q;
            5'd4: do_d[DIM_W-1:0] = width_q;
            5'd5: do_d[DIM_W-1:0] = height_q;
            default: begin
                for (int i = 0; i < 9; i++) begin
                    if (reg_address == 5'(i + 6))
                        do_d = {{(DATA_W-COEF_W){k_q[i][COEF_W-1]}}, k_q[i]};
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src_q     <= '0;
            dst_q     <= '0;
            width_q   <= '0;
            height_q  <= '0;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            pending_q <= 1'b0;
            start_q   <= 1'b0;
            irq       <= 1'b0;
            do_q      <= '0;
            for (int i = 0; i < 9; i++)
                k_q[i] <= kDefault(i);
        end else begin
            irq_en_q  <= irq_en_d;
            done_q    <= done_d;
            err_q     <= err_d;
            pending_q <= pending_d;
            start_q   <= startOk;
            irq       <= irq_d;
            do_q      <= do_d;
            if (accessWr) begin
                case (reg_address)
                    5'd2: src_q    <= DI;
                    5'd3: dst_q    <= DI;
                    5'd4: width_q  <= DI[DIM_W-1:0];
                    5'd5: height_q <= DI[DIM_W-1:0];
                    default: begin
                        for (int i = 0; i < 9; i++) begin
                            if (reg_address == 5'(i + 6))
                                k_q[i] <= DI[COEF_W-1:0];
                        end
                    end
                endcase
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < 9; g++) begin : gKernel
            assign kernel[g*COEF_W +: COEF_W] = k_q[g];
        end
    endgenerate

    assign DO         = do_q;
    assign DO_EN      = ~SACK_N & WR_N;
    assign eng_start  = start_q;
    assign src_addr   = src_q;
    assign dst_addr   = dst_q;
    assign img_width  = width_q;
    assign img_height = height_q;

endmodule

// File: tb/tb_sharp_reg_bank.sv
// Scoreboard bench for sharp_reg_bank: reads push expected DO values, a
// monitor pops and compares whenever the DUT drives the bus.
module tb_sharp_reg_bank;

    localparam int DATA_W = 32;
    localparam int DIM_W  = 10;
    localparam int COEF_W = 8;
    localparam logic [71:0] K_DEFAULT = 72'h00_FF_00_FF_05_FF_00_FF_00;

    logic                clk = 1'b0;
    logic                reset;
    logic [4:0]          reg_address;
    logic                SACK_N;
    logic                WR_N;
    logic [DATA_W-1:0]   DI;
    logic [DATA_W-1:0]   DO;
    logic                DO_EN;
    logic                eng_start;
    logic                eng_busy;
    logic                eng_done;
    logic [DATA_W-1:0]   src_addr;
    logic [DATA_W-1:0]   dst_addr;
    logic [DIM_W-1:0]    img_width;
    logic [DIM_W-1:0]    img_height;
    logic [9*COEF_W-1:0] kernel;
    logic                irq;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] val;
    } rd_exp_t;

    rd_exp_t expQ[$];
    int checks = 0;
    int errors = 0;
    int startCount = 0;
    logic [31:0] readTable [15];

    sharp_reg_bank #(.DATA_W(DATA_W), .DIM_W(DIM_W), .COEF_W(COEF_W)) dut (
        .clk(clk), .reset(reset), .reg_address(reg_address), .SACK_N(SACK_N),
        .WR_N(WR_N), .DI(DI), .DO(DO), .DO_EN(DO_EN), .eng_start(eng_start),
        .eng_busy(eng_busy), .eng_done(eng_done), .src_addr(src_addr),
        .dst_addr(dst_addr), .img_width(img_width), .img_height(img_height),
        .kernel(kernel), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every driven read cycle consumes one scoreboard entry.
    always @(negedge clk) begin
        if (DO_EN) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_read", {40'd0, DO}, 72'hDEAD);
            end else begin
                rd_exp_t e;
                e = expQ.pop_front();
                checkOutput($sformatf("rd_reg%0d", e.addr), {40'd0, DO}, {40'd0, e.val});
            end
        end
        if (eng_start) startCount++;
    end

    task automatic readReg(input logic [4:0] addr, input logic [31:0] exp);
        rd_exp_t e;
        reg_address = addr;
        @(posedge clk) #1;
        SACK_N = 1'b0;
        WR_N   = 1'b1;
        e.addr = addr;
        e.val  = exp;
        expQ.push_back(e);
        @(posedge clk) #1;
        SACK_N = 1'b1;
    endtask

    task automatic applyStimulus(input logic [4:0] addr, input logic [31:0] data, input logic doneDuring);
        reg_address = addr;
        @(posedge clk) #1;
        SACK_N   = 1'b0;
        WR_N     = 1'b0;
        DI       = data;
        eng_done = doneDuring;
        @(posedge clk) #1;
        SACK_N   = 1'b1;
        WR_N     = 1'b1;
        eng_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int startBase;
        reset = 1'b1; reg_address = '0; SACK_N = 1'b1; WR_N = 1'b1;
        DI = '0; eng_busy = 1'b0; eng_done = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_eng_start", {71'd0, eng_start}, 72'd0);
        checkOutput("rst_irq", {71'd0, irq}, 72'd0);
        checkOutput("rst_kernel", kernel, K_DEFAULT);
        for (int i = 0; i < 15; i++) readTable[i] = 32'h0;
        readTable[7] = 32'hFFFFFFFF; readTable[9] = 32'hFFFFFFFF;
        readTable[10] = 32'h00000005;
        readTable[11] = 32'hFFFFFFFF; readTable[13] = 32'hFFFFFFFF;
        for (int i = 0; i < 15; i++) readReg(5'(i), readTable[i]);

        $display("[TB] config write/readback");
        applyStimulus(5'd2, 32'h00001000, 1'b0);
        applyStimulus(5'd4, 32'hFFFFF280, 1'b0);
        applyStimulus(5'd6, 32'h000000FE, 1'b0);
        applyStimulus(5'd3, 32'hCAFE0004, 1'b0);
        readReg(5'd2, 32'h00001000);
        readReg(5'd4, 32'h00000280);
        readReg(5'd6, 32'hFFFFFFFE);
        readReg(5'd3, 32'hCAFE0004);
        checkOutput("src_addr", {40'd0, src_addr}, {40'd0, 32'h00001000});
        checkOutput("img_width", {62'd0, img_width}, {62'd0, 10'h280});
        checkOutput("kernel_k0", {64'd0, kernel[7:0]}, {64'd0, 8'hFE});
        applyStimulus(5'd20, 32'h00001234, 1'b0);
        readReg(5'd20, 32'h0);

        $display("[TB] start and done");
        applyStimulus(5'd0, 32'h3, 1'b0);
        checkOutput("start_pulse", {71'd0, eng_start}, 72'd1);
        eng_busy = 1'b1;
        @(posedge clk) #1;
        checkOutput("start_one_cycle", {71'd0, eng_start}, 72'd0);
        repeat (9) @(posedge clk);
        #1 eng_busy = 1'b0; eng_done = 1'b1;
        @(posedge clk) #1 eng_done = 1'b0;
        checkOutput("irq_after_done", {71'd0, irq}, 72'd1);
        readReg(5'd1, 32'h2);
        readReg(5'd0, 32'h2);

        $display("[TB] W1C versus done");
        applyStimulus(5'd1, 32'h2, 1'b1);
        readReg(5'd1, 32'h2);
        checkOutput("irq_held", {71'd0, irq}, 72'd1);
        applyStimulus(5'd1, 32'h2, 1'b0);
        checkOutput("irq_fall", {71'd0, irq}, 72'd0);
        readReg(5'd1, 32'h0);

        $display("[TB] start while busy, double start");
        eng_busy = 1'b1;
        startBase = startCount;
        applyStimulus(5'd0, 32'h1, 1'b0);
        checkOutput("busy_no_start", {71'd0, eng_start}, 72'd0);
        readReg(5'd1, 32'h5);
        eng_busy = 1'b0;
        applyStimulus(5'd0, 32'h1, 1'b0);
        applyStimulus(5'd0, 32'h1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("single_start", 72'(startCount - startBase), 72'd1);

        $display("[TB] reset mid-operation");
        eng_done = 1'b1;
        @(posedge clk) #1 eng_done = 1'b0;
        applyStimulus(5'd0, 32'h2, 1'b0);
        applyStimulus(5'd7, 32'h00000033, 1'b0);
        checkOutput("pre_rst_irq", {71'd0, irq}, 72'd1);
        readReg(5'd1, 32'h6);
        reg_address = 5'd0;
        @(posedge clk) #1;
        SACK_N = 1'b0; WR_N = 1'b0; DI = 32'h1; reset = 1'b1; eng_done = 1'b1;
        @(posedge clk) #1;
        SACK_N = 1'b1; WR_N = 1'b1; reset = 1'b0; eng_done = 1'b0;
        checkOutput("rst_mid_start", {71'd0, eng_start}, 72'd0);
        checkOutput("rst_mid_irq", {71'd0, irq}, 72'd0);
        checkOutput("rst_mid_kernel", kernel, K_DEFAULT);
        @(posedge clk) #1;
        checkOutput("rst_mid_start_late", {71'd0, eng_start}, 72'd0);
        readReg(5'd1, 32'h0);
        readReg(5'd0, 32'h0);
        readReg(5'd2, 32'h0);

        for (int i = 0; i < 20 && expQ.size() != 0; i++) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", 72'(expQ.size()), 72'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
